// File: rtl/dffers_pkg.sv
// rtl/dffers_pkg.sv - shared constants and helpers for the dffers elastic pipeline
package dffers_pkg;

    localparam int SETPRIO_RESET = 0;
    localparam int SETPRIO_SET   = 1;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffers_stage.sv
// rtl/dffers_stage.sv - one pipeline stage: data register plus valid flag with sync reset/set
module dffers_stage
    import dffers_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter logic [WIDTH-1:0] SET_VAL  = '1,
    parameter int               SET_PRIO = SETPRIO_RESET
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_set,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_do_rst;
    logic             w_do_set;

    assign w_do_rst = i_rst && (!i_set || (SET_PRIO == SETPRIO_RESET));
    assign w_do_set = i_set && !w_do_rst;

    // Set rewrites data only; the valid flag survives so in-flight words keep their slots.
    always_ff @(posedge clk) begin
        if (w_do_rst) begin
            r_data  <= RST_VAL;
            r_valid <= 1'b0;
        end else if (w_do_set) begin
            r_data  <= SET_VAL;
        end else if (i_en) begin
            if (i_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (i_adv) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/dffers_pipe.sv
// rtl/dffers_pipe.sv - DEPTH-stage elastic register pipeline with CE, sync reset/set and handshake
module dffers_pipe
    import dffers_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter logic [WIDTH-1:0] SET_VAL  = '1,
    parameter int               SET_PRIO = SETPRIO_RESET
) (
    input  logic                      clk,
    input  logic                      R,
    input  logic                      S,
    input  logic                      E,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [WIDTH-1:0] w_din  [DEPTH];
    logic             w_normal;
    logic             w_pop;
    logic             w_push;
    logic             w_do_rst;
    logic [CW-1:0]    r_count;

    assign w_normal  = E && !R && !S;
    assign out_valid = w_valid[DEPTH-1] && E;
    assign out_data  = w_data[DEPTH-1];
    assign w_pop     = w_normal && out_valid && out_ready;
    assign in_ready  = w_normal && (!w_valid[0] || w_adv[0]);
    assign w_push    = in_valid && in_ready;
    assign w_do_rst  = R && (!S || (SET_PRIO == SETPRIO_RESET));

    // Advance ripples back from the output, so any bubble lets everything behind it move up.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == DEPTH - 1) begin : g_last
            assign w_adv[i] = w_valid[i] && w_pop;
        end else begin : g_mid
            assign w_adv[i] = w_normal && w_valid[i] && (!w_valid[i+1] || w_adv[i+1]);
        end

        if (i == 0) begin : g_first
            assign w_load[i] = w_push;
            assign w_din[i]  = in_data;
        end else begin : g_chain
            assign w_load[i] = w_adv[i-1];
            assign w_din[i]  = w_data[i-1];
        end

        dffers_stage #(
            .WIDTH    (WIDTH),
            .RST_VAL  (RST_VAL),
            .SET_VAL  (SET_VAL),
            .SET_PRIO (SET_PRIO)
        ) u_stage (
            .clk     (clk),
            .i_rst   (R),
            .i_set   (S),
            .i_en    (E),
            .i_load  (w_load[i]),
            .i_adv   (w_adv[i]),
            .i_data  (w_din[i]),
            .o_data  (w_data[i]),
            .o_valid (w_valid[i])
        );
    end

    always_ff @(posedge clk) begin
        if (w_do_rst) begin
            r_count <= '0;
        end else if (w_normal) begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_dffers_pipe.sv
// tb/tb_dffers_pipe.sv - self-checking bench for dffers_pipe, SET_PRIO=0 and SET_PRIO=1 instances
module tb_dffers_pipe;

    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       R, S, E, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;
    logic [2:0] count0, count1;

    dffers_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'h00), .SET_VAL(8'hFF), .SET_PRIO(0)) dut0 (
        .clk(clk), .R(R), .S(S), .E(E), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .count(count0)
    );

    dffers_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'h00), .SET_VAL(8'hFF), .SET_PRIO(1)) dut1 (
        .clk(clk), .R(R), .S(S), .E(E), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .count(count1)
    );

    logic       a_outv [2];
    logic       a_rdy  [2];
    logic [2:0] a_cnt  [2];
    logic [7:0] a_dout [2];
    assign a_outv[0] = out_valid0;  assign a_outv[1] = out_valid1;
    assign a_rdy[0]  = in_ready0;   assign a_rdy[1]  = in_ready1;
    assign a_cnt[0]  = count0;      assign a_cnt[1]  = count1;
    assign a_dout[0] = out_data0;   assign a_dout[1] = out_data1;

    int checks = 0;
    int errors = 0;

    // Reference: per instance, an ordered list of words (oldest first) and each word's slot index.
    int         m_cnt  [2];
    logic [7:0] m_data [2][D];
    int         m_pos  [2][D];
    logic       e_outv [2];
    logic       e_rdy  [2];
    int         e_cnt  [2];
    logic [7:0] e_dout [2];
    logic [7:0] got0[$];
    logic [7:0] got1[$];

    task automatic settle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e_cnt[k]  = m_cnt[k];
            e_outv[k] = E && (m_cnt[k] > 0) && (m_pos[k][0] == D - 1);
            e_dout[k] = m_data[k][0];
            e_rdy[k]  = E && !R && !S && ((m_cnt[k] < D) || (e_outv[k] && out_ready));
        end
    endtask

    task automatic step();
        logic do_rst, do_set, pop, push;
        int   lim;
        if (E && !R && !S && out_valid0 && out_ready) got0.push_back(out_data0);
        if (E && !R && !S && out_valid1 && out_ready) got1.push_back(out_data1);
        for (int k = 0; k < 2; k++) begin
            do_rst = R && (!S || k == 0);
            do_set = S && !do_rst;
            if (do_rst) begin
                m_cnt[k] = 0;
            end else if (do_set) begin
                for (int j = 0; j < m_cnt[k]; j++) m_data[k][j] = 8'hFF;
            end else if (E) begin
                pop  = e_outv[k] && out_ready;
                push = in_valid && e_rdy[k];
                if (pop) begin
                    for (int j = 0; j < m_cnt[k] - 1; j++) begin
                        m_data[k][j] = m_data[k][j+1];
                        m_pos[k][j]  = m_pos[k][j+1];
                    end
                    m_cnt[k]--;
                end
                lim = D;
                for (int j = 0; j < m_cnt[k]; j++) begin
                    if (m_pos[k][j] + 1 < lim) m_pos[k][j]++;
                    lim = m_pos[k][j];
                end
                if (push) begin
                    m_data[k][m_cnt[k]] = in_data;
                    m_pos[k][m_cnt[k]]  = 0;
                    m_cnt[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        R = 1'b1; S = 1'b0; E = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        settle(); step();
        R = 1'b0;
    endtask

    task automatic test_reset();
        R = 1'b1; S = 1'b0; E = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        for (int c = 0; c < 2; c++) begin settle(); step(); end
        R = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) begin
            checks++; if (a_outv[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %0b exp 0", k, a_outv[k]); end
            checks++; if (a_cnt[k] !== 3'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d exp 0", k, a_cnt[k]); end
            checks++; if (a_rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %0b exp 1", k, a_rdy[k]); end
            checks++; if (a_dout[k] !== 8'h00) begin errors++; $display("FAIL reset_out_data[%0d] got %02h exp 00", k, a_dout[k]); end
        end
        step();
    endtask

    task automatic test_stream();
        int first = -1;
        do_reset();
        got0.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            in_data  = 8'(c + 1);
            settle();
            if (out_valid0 && first < 0) begin
                first = c;
                checks++; if (count0 !== 3'd4) begin errors++; $display("FAIL stream_count got %0d exp 4", count0); end
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (first != D) begin errors++; $display("FAIL stream_latency got %0d exp %0d", first, D); end
        checks++; if (got0.size() != 8) begin errors++; $display("FAIL stream_words got %0d exp 8", got0.size()); end
        for (int i = 0; i < got0.size() && i < 8; i++) begin
            checks++; if (got0[i] !== 8'(i + 1)) begin errors++; $display("FAIL stream_order[%0d] got %02h exp %02h", i, got0[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_full();
        do_reset();
        got0.delete();
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = 8'(8'h10 + c);
            settle(); step();
        end
        settle();
        checks++; if (count0 !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count0); end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b exp 0", in_ready0); end
        step();
        out_ready = 1'b1; in_data = 8'h20;
        settle();
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL full_passthru_ready got %0b exp 1", in_ready0); end
        checks++; if (out_data0 !== 8'h10) begin errors++; $display("FAIL full_head got %02h exp 10", out_data0); end
        step();
        in_valid = 1'b0;
        settle();
        checks++; if (count0 !== 3'd4) begin errors++; $display("FAIL full_count_after got %0d exp 4", count0); end
        step();
        for (int c = 0; c < 8; c++) begin settle(); step(); end
        checks++; if (got0.size() != 5) begin errors++; $display("FAIL full_words got %0d exp 5", got0.size()); end
        for (int i = 0; i < got0.size() && i < 5; i++) begin
            checks++; if (got0[i] !== ((i < 4) ? 8'(8'h10 + i) : 8'h20)) begin errors++; $display("FAIL full_order[%0d] got %02h", i, got0[i]); end
        end
    endtask

    task automatic test_enable();
        logic [7:0] words[6];
        int idx = 0;
        for (int i = 0; i < 6; i++) words[i] = 8'(8'h31 + i);
        do_reset();
        got0.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            E        = !(c >= 3 && c <= 5);
            in_valid = (idx < 6);
            in_data  = words[idx < 6 ? idx : 5];
            settle();
            if (!E) begin
                checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL enable_in_ready c%0d got %0b exp 0", c, in_ready0); end
                checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL enable_out_valid c%0d got %0b exp 0", c, out_valid0); end
            end
            if (c >= 3 && c <= 6) begin
                checks++; if (count0 !== 3'd3) begin errors++; $display("FAIL enable_count c%0d got %0d exp 3", c, count0); end
            end
            if (in_valid && in_ready0) idx++;
            step();
        end
        E = 1'b1; in_valid = 1'b0;
        checks++; if (got0.size() != 6) begin errors++; $display("FAIL enable_words got %0d exp 6", got0.size()); end
        for (int i = 0; i < got0.size() && i < 6; i++) begin
            checks++; if (got0[i] !== words[i]) begin errors++; $display("FAIL enable_order[%0d] got %02h exp %02h", i, got0[i], words[i]); end
        end
    endtask

    task automatic test_set_reset();
        do_reset();
        in_valid = 1'b1; in_data = 8'hA1; settle(); step();
        in_data = 8'hA2; settle(); step();
        in_valid = 1'b0; settle(); step();
        S = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        settle();
        checks++; if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin errors++; $display("FAIL set_in_ready got %0b/%0b exp 0/0", in_ready0, in_ready1); end
        step();
        S = 1'b0; in_valid = 1'b0;
        settle();
        checks++; if (count0 !== 3'd2 || count1 !== 3'd2) begin errors++; $display("FAIL set_count got %0d/%0d exp 2/2", count0, count1); end
        checks++; if (out_data0 !== 8'hFF || out_data1 !== 8'hFF) begin errors++; $display("FAIL set_last_stage got %02h/%02h exp FF/FF", out_data0, out_data1); end
        step();
        got0.delete(); got1.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin settle(); step(); end
        checks++; if (got0.size() != 2 || got1.size() != 2) begin errors++; $display("FAIL set_drain_words got %0d/%0d exp 2/2", got0.size(), got1.size()); end
        for (int i = 0; i < got0.size(); i++) begin
            checks++; if (got0[i] !== 8'hFF) begin errors++; $display("FAIL set_drain0[%0d] got %02h exp FF", i, got0[i]); end
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hB1; settle(); step();
        in_data = 8'hB2; settle(); step();
        in_valid = 1'b0; R = 1'b1; S = 1'b1;
        settle(); step();
        R = 1'b0; S = 1'b0;
        settle();
        checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL rs_prio0_count got %0d exp 0", count0); end
        checks++; if (count1 !== 3'd2) begin errors++; $display("FAIL rs_prio1_count got %0d exp 2", count1); end
        step();
        got0.delete(); got1.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin settle(); step(); end
        checks++; if (got0.size() != 0) begin errors++; $display("FAIL rs_prio0_words got %0d exp 0", got0.size()); end
        checks++; if (got1.size() != 2) begin errors++; $display("FAIL rs_prio1_words got %0d exp 2", got1.size()); end
        for (int i = 0; i < got1.size(); i++) begin
            checks++; if (got1[i] !== 8'hFF) begin errors++; $display("FAIL rs_prio1_data[%0d] got %02h exp FF", i, got1[i]); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        do_reset();
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin in_data = 8'(8'h60 + c); settle(); step(); end
        R = 1'b1; out_ready = 1'b1; in_data = 8'h70;
        settle(); step();
        R = 1'b0; in_valid = 1'b0;
        settle();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rstfull_out_valid got %0b exp 0", out_valid0); end
        checks++; if (count0 !== 3'd0 || count1 !== 3'd0) begin errors++; $display("FAIL rstfull_count got %0d/%0d exp 0/0", count0, count1); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            R         = ($urandom_range(0, 49) == 0);
            S         = ($urandom_range(0, 39) == 0);
            E         = ($urandom_range(0, 7) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_data   = 8'($urandom);
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++; if (a_outv[k] !== e_outv[k]) begin errors++; $display("FAIL rand_out_valid[%0d] c%0d got %0b exp %0b", k, c, a_outv[k], e_outv[k]); end
                checks++; if (a_rdy[k] !== e_rdy[k]) begin errors++; $display("FAIL rand_in_ready[%0d] c%0d got %0b exp %0b", k, c, a_rdy[k], e_rdy[k]); end
                checks++; if (a_cnt[k] !== 3'(e_cnt[k])) begin errors++; $display("FAIL rand_count[%0d] c%0d got %0d exp %0d", k, c, a_cnt[k], e_cnt[k]); end
                if (e_outv[k]) begin
                    checks++; if (a_dout[k] !== e_dout[k]) begin errors++; $display("FAIL rand_out_data[%0d] c%0d got %02h exp %02h", k, c, a_dout[k], e_dout[k]); end
                end
            end
            step();
        end
        R = 1'b0; S = 1'b0; E = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0;
        R = 1'b1; S = 1'b0; E = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        #1;
        test_reset();
        test_stream();
        test_full();
        test_enable();
        test_set_reset();
        test_reset_full();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
